// File: rtl/aes_round_sequencer_if.sv
// Client-side request/response handshakes of the AES round sequencer.
interface aes_round_sequencer_if #(
   parameter int ID_W = 2
);
   logic            in_valid;
   logic            in_ready;
   logic [127:0]    in_data;
   logic [ID_W-1:0] in_id;
   logic            out_valid;
   logic            out_ready;
   logic [127:0]    out_data;
   logic [ID_W-1:0] out_id;

   // client side: issues plaintext, consumes ciphertext
   modport master (
      output in_valid, in_data, in_id, out_ready,
      input  in_ready, out_valid, out_data, out_id
   );

   // sequencer side
   modport slave (
      input  in_valid, in_data, in_id, out_ready,
      output in_ready, out_valid, out_data, out_id
   );
endinterface

// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption controller: owns the state register, round counter
// and handshakes around an external combinational round datapath (dp_*).
module aes_round_sequencer #(
   parameter int NK   = 4,
   parameter int NR   = NK + 6,
   parameter int ID_W = 2
) (
   input  logic                 clks,
   input  logic                 reset,
   aes_round_sequencer_if.slave bus,
   input  logic [127:0]         key0,
   output logic [127:0]         dp_state,
   output logic [3:0]           dp_round,
   output logic                 dp_final,
   input  logic [127:0]         dp_result,
   output logic                 busy
);
   localparam logic [3:0] LAST_RND = 4'(NR);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_ROUND = 2'b01,
      S_DONE  = 2'b10
   } fsm_e;

   fsm_e            fsm_q, fsm_d;
   logic [3:0]      round_q, round_d;
   logic [127:0]    state_q, state_d;
   logic [ID_W-1:0] id_q, id_d;
   logic            out_valid_q, out_valid_d;
   logic [127:0]    out_data_q, out_data_d;
   logic [ID_W-1:0] out_id_q, out_id_d;
   logic            in_ready_w;
   logic            in_round;

   assign in_ready_w   = (fsm_q == S_IDLE) & ~reset;
   assign in_round     = (fsm_q == S_ROUND);
   assign bus.in_ready = in_ready_w;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_id    = out_id_q;
   assign dp_state     = state_q;
   assign dp_round     = in_round ? round_q : 4'd0;
   assign dp_final     = in_round & (round_q == LAST_RND);
   assign busy         = (fsm_q == S_ROUND) | (fsm_q == S_DONE);

   // next-state: accept in IDLE, one datapath round per cycle, hold result until consumed
   always_comb begin
      fsm_d       = fsm_q;
      round_d     = round_q;
      state_d     = state_q;
      id_d        = id_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_id_d    = out_id_q;
      case (fsm_q)
         S_IDLE: begin
            if (bus.in_valid & in_ready_w) begin
               // initial AddRoundKey with key 0 is done here, not in the datapath
               state_d = bus.in_data ^ key0;
               id_d    = bus.in_id;
               round_d = 4'd1;
               fsm_d   = S_ROUND;
            end
         end
         S_ROUND: begin
            state_d = dp_result;
            if (round_q == LAST_RND) begin
               out_data_d  = dp_result;
               out_id_d    = id_q;
               out_valid_d = 1'b1;
               fsm_d       = S_DONE;
            end else begin
               round_d = round_q + 4'd1;
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               round_d     = 4'd0;
               fsm_d       = S_IDLE;
            end
         end
         default: begin
            // unused encoding recovers to IDLE
            out_valid_d = 1'b0;
            round_d     = 4'd0;
            fsm_d       = S_IDLE;
         end
      endcase
   end

   // state registers; reset abandons any block in flight
   always_ff @(posedge clks) begin
      if (reset) begin
         fsm_q       <= S_IDLE;
         round_q     <= 4'd0;
         state_q     <= '0;
         id_q        <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
      end else begin
         fsm_q       <= fsm_d;
         round_q     <= round_d;
         state_q     <= state_d;
         id_q        <= id_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_id_q    <= out_id_d;
      end
   end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench: two sequencers (AES-128 and AES-256) driven by a behavioural AES round
// datapath, checked every cycle against a cycle-level transaction model.
module tb_aes_round_sequencer;
   logic clks = 1'b0;
   logic reset = 1'b1;
   always #5 clks = ~clks;

   int total = 0;
   int bad   = 0;

   logic [1:0]         in_valid = '0;
   logic [1:0][127:0]  in_data  = '0;
   logic [1:0][1:0]    in_id    = '0;
   logic [1:0][127:0]  key0     = '0;
   logic [1:0]         out_ready = '0;
   logic [1:0]         in_rdy, o_valid, dp_fin, bsy;
   logic [1:0][127:0]  o_data, dp_st, dp_res;
   logic [1:0][1:0]    o_id;
   logic [1:0][3:0]    dp_rnd;

   logic [7:0]   sbox_t [256];
   logic [127:0] rk [2][16];

   localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
   localparam logic [255:0] KEY4  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] KEY8  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] CT4   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT8   = 128'h8ea2b7ca516745bfeafc49904b496089;

   task automatic chk(input int k, input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL dut%0d %s got=%h want=%h t=%0t", k, nm, act, exp, $time);
      end
   endtask

   // ---- AES reference arithmetic (GF(2^8), S-box, round, key schedule) ----
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rl(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_t[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
   endfunction

   // byte i of a block sits at bits [127-8i -: 8]; column c holds bytes 4c..4c+3
   function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rkey, input logic fin);
      logic [7:0] a [16];
      logic [7:0] b [16];
      logic [7:0] s0, s1, s2, s3;
      logic [127:0] r = '0;
      for (int i = 0; i < 16; i++) a[i] = sbox_t[st[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
         for (int rr = 0; rr < 4; rr++) b[4*c+rr] = a[4*((c+rr)%4)+rr];
      if (!fin) begin
         for (int c = 0; c < 4; c++) begin
            s0 = b[4*c]; s1 = b[4*c+1]; s2 = b[4*c+2]; s3 = b[4*c+3];
            b[4*c]   = xt(s0) ^ xt(s1) ^ s1 ^ s2 ^ s3;
            b[4*c+1] = s0 ^ xt(s1) ^ xt(s2) ^ s2 ^ s3;
            b[4*c+2] = s0 ^ s1 ^ xt(s2) ^ xt(s3) ^ s3;
            b[4*c+3] = xt(s0) ^ s0 ^ s1 ^ s2 ^ xt(s3);
         end
      end
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
      return r ^ rkey;
   endfunction

   task automatic expand(input int k, input logic [255:0] key, input int nk);
      logic [31:0] w [64];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      int nw = 4 * (nk + 7);
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < nw; i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end else if (nk > 6 && i % nk == 4) begin
            t = subw(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r <= nk + 6; r++) rk[k][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] aes_encrypt(input int k, input logic [127:0] pt, input int nr);
      logic [127:0] s = pt ^ rk[k][0];
      for (int r = 1; r <= nr; r++) s = aes_round(s, rk[k][r], r == nr);
      return s;
   endfunction

   // ---- DUTs, behavioural datapaths and per-cycle transaction model ----
   for (genvar k = 0; k < 2; k++) begin : g
      localparam int NRK = (k == 0) ? 10 : 14;
      aes_round_sequencer_if #(.ID_W(2)) bus ();

      aes_round_sequencer #(.NK(NRK - 6), .ID_W(2)) dut (
         .clks(clks), .reset(reset), .bus(bus), .key0(key0[k]),
         .dp_state(dp_st[k]), .dp_round(dp_rnd[k]), .dp_final(dp_fin[k]),
         .dp_result(dp_res[k]), .busy(bsy[k])
      );

      assign bus.in_valid  = in_valid[k];
      assign bus.in_data   = in_data[k];
      assign bus.in_id     = in_id[k];
      assign bus.out_ready = out_ready[k];
      assign in_rdy[k]     = bus.in_ready;
      assign o_valid[k]    = bus.out_valid;
      assign o_data[k]     = bus.out_data;
      assign o_id[k]       = bus.out_id;
      assign dp_res[k]     = aes_round(dp_st[k], rk[k][dp_rnd[k]], dp_fin[k]);

      // ph: 0 idle, 1..NRK round number, NRK+1 result waiting for the consumer
      int           ph    = 0;
      logic         mv    = 1'b0;
      logic [127:0] md    = '0;
      logic [127:0] pend  = '0;
      logic [127:0] first = '0;
      logic [1:0]   mid   = '0;
      logic [1:0]   pid   = '0;

      always @(posedge clks) begin
         if (reset) begin
            ph <= 0; mv <= 1'b0; md <= '0; mid <= '0;
         end else if (ph == 0) begin
            if (in_valid[k]) begin
               ph    <= 1;
               pend  <= aes_encrypt(k, in_data[k], NRK);
               pid   <= in_id[k];
               first <= in_data[k] ^ key0[k];
            end
         end else if (ph < NRK) begin
            ph <= ph + 1;
         end else if (ph == NRK) begin
            ph <= NRK + 1; mv <= 1'b1; md <= pend; mid <= pid;
         end else if (out_ready[k]) begin
            ph <= 0; mv <= 1'b0;
         end
      end

      always @(posedge clks) begin
         #1;
         chk(k, "in_ready", 128'(in_rdy[k]), 128'((ph == 0) && !reset));
         chk(k, "busy", 128'(bsy[k]), 128'(ph > 0));
         chk(k, "dp_round", 128'(dp_rnd[k]), 128'((ph >= 1 && ph <= NRK) ? ph : 0));
         chk(k, "dp_final", 128'(dp_fin[k]), 128'(ph == NRK));
         chk(k, "out_valid", 128'(o_valid[k]), 128'(mv));
         chk(k, "out_data", o_data[k], md);
         chk(k, "out_id", 128'(o_id[k]), 128'(mid));
         if (ph == 1) chk(k, "dp_state", dp_st[k], first);
      end
   end

   // ---- stimulus helpers ----
   task automatic send(input int k, input logic [127:0] d, input logic [1:0] id, input bit hold);
      int n = 0;
      @(negedge clks);
      in_valid[k] = 1'b1; in_data[k] = d; in_id[k] = id; key0[k] = rk[k][0];
      while (!in_rdy[k] && n < 40) begin
         @(negedge clks);
         n++;
      end
      if (n >= 40) chk(k, "accept timeout", 128'(n), 128'(0));
      @(posedge clks); #1;
      if (!hold) in_valid[k] = 1'b0;
   endtask

   // waits from one cycle after the accept edge until out_valid, checking the round index
   task automatic wait_out(input int k, output int lat);
      int nr = (k == 0) ? 10 : 14;
      lat = 0;
      chk(k, "first dp_round", 128'(dp_rnd[k]), 128'(1));
      forever begin
         @(posedge clks); #1;
         lat++;
         if (o_valid[k]) break;
         if (lat > 40) begin
            chk(k, "result timeout", 128'(lat), 128'(nr));
            break;
         end
         chk(k, "seq dp_round", 128'(dp_rnd[k]), 128'(lat + 1));
         chk(k, "seq dp_final", 128'(dp_fin[k]), 128'(lat + 1 == nr));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, n;
      build_sbox();
      expand(0, KEY4, 4);
      expand(1, KEY8, 8);
      // pin the reference arithmetic to FIPS-197 values
      chk(0, "sbox 00", 128'(sbox_t[8'h00]), 128'(8'h63));
      chk(0, "sbox 53", 128'(sbox_t[8'h53]), 128'(8'hed));
      chk(0, "rk10", rk[0][10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
      chk(1, "rk14", rk[1][14], 128'h24fc79ccbf0979e9371ac23c6d68de36);
      chk(0, "round1", aes_round(128'h00102030405060708090a0b0c0d0e0f0, rk[0][1], 1'b0),
          128'h89d810e8855ace682d1843d8cb128fe4);
      chk(0, "model ct4", aes_encrypt(0, PT, 10), CT4);
      chk(1, "model ct8", aes_encrypt(1, PT, 14), CT8);

      out_ready[1] = 1'b1;
      repeat (2) @(posedge clks);
      #1;
      chk(0, "reset out_valid", 128'(o_valid[0]), 128'(0));
      chk(0, "reset out_data", o_data[0], 128'(0));
      chk(0, "reset in_ready", 128'(in_rdy[0]), 128'(0));
      @(negedge clks); reset = 1'b0;
      #1 chk(0, "post-reset in_ready", 128'(in_rdy[0]), 128'(1));

      // 1+2: FIPS-197 AES-128, then hold the result under backpressure
      send(0, PT, 2'd2, 1'b0);
      wait_out(0, lat);
      chk(0, "t1 latency", 128'(lat), 128'(10));
      chk(0, "t1 out_data", o_data[0], CT4);
      chk(0, "t1 out_id", 128'(o_id[0]), 128'(2));
      repeat (5) begin
         @(posedge clks); #1;
         chk(0, "bp out_valid", 128'(o_valid[0]), 128'(1));
         chk(0, "bp out_data", o_data[0], CT4);
         chk(0, "bp out_id", 128'(o_id[0]), 128'(2));
         chk(0, "bp in_ready", 128'(in_rdy[0]), 128'(0));
         chk(0, "bp busy", 128'(bsy[0]), 128'(1));
      end
      @(negedge clks); out_ready[0] = 1'b1;
      @(posedge clks); #1;
      chk(0, "release out_valid", 128'(o_valid[0]), 128'(0));
      chk(0, "release in_ready", 128'(in_rdy[0]), 128'(1));

      // 3: back-to-back with in_valid held high
      send(0, PT, 2'd1, 1'b1);
      @(negedge clks); in_data[0] = PT + 128'd1; in_id[0] = 2'd2;
      wait_out(0, lat);
      chk(0, "b2b first id", 128'(o_id[0]), 128'(1));
      chk(0, "b2b first data", o_data[0], CT4);
      n = 0;
      do begin
         @(posedge clks); #1;
         n++;
      end while (!o_valid[0] && n < 40);
      @(negedge clks); in_valid[0] = 1'b0;
      chk(0, "b2b spacing", 128'(n), 128'(12));
      chk(0, "b2b second id", 128'(o_id[0]), 128'(2));
      chk(0, "b2b second data", o_data[0], aes_encrypt(0, PT + 128'd1, 10));

      // 4: in_valid pulsed mid-block with unrelated data and key is ignored
      send(0, PT, 2'd3, 1'b0);
      @(negedge clks); @(negedge clks);
      in_valid[0] = 1'b1; in_data[0] = ~PT; in_id[0] = 2'd0; key0[0] = '1;
      @(negedge clks); @(negedge clks);
      in_valid[0] = 1'b0;
      n = 0;
      while (!o_valid[0] && n < 40) begin
         @(posedge clks); #1;
         n++;
      end
      chk(0, "ignore out_data", o_data[0], CT4);
      chk(0, "ignore out_id", 128'(o_id[0]), 128'(3));
      @(posedge clks); #1;

      // 5: one-cycle reset at round 5 abandons the block
      send(0, PT, 2'd1, 1'b0);
      n = 0;
      while (dp_rnd[0] != 4'd5 && n < 40) begin
         @(posedge clks); #1;
         n++;
      end
      chk(0, "reached round5", 128'(dp_rnd[0]), 128'(5));
      @(negedge clks); reset = 1'b1;
      @(negedge clks); reset = 1'b0;
      #1 chk(0, "rst in_ready", 128'(in_rdy[0]), 128'(1));
      repeat (12) begin
         @(posedge clks); #1;
         chk(0, "rst no result", 128'(o_valid[0]), 128'(0));
      end
      send(0, PT, 2'd3, 1'b0);
      wait_out(0, lat);
      chk(0, "rst latency", 128'(lat), 128'(10));
      chk(0, "rst out_data", o_data[0], CT4);

      // 6: FIPS-197 AES-256
      send(1, PT, 2'd1, 1'b0);
      wait_out(1, lat);
      chk(1, "t6 latency", 128'(lat), 128'(14));
      chk(1, "t6 out_data", o_data[1], CT8);
      repeat (3) @(posedge clks);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
